device_fifo: RTL
================

# device_fifo

Per-device transmit FIFO that sits directly upstream of the shared bus: the device (or the testbench driver) pushes packets into it, and the bus arbiter pops them when it grants this device. One instance per bus port (devices = 4 in the standard configuration). It presents a first-word-fall-through head word plus a pending flag to the bus. It also reports occupancy and a sticky overflow error.

## Interface
- width, 16, packet width in bits; upper 8 bits are the destination ID, lower width-8 bits are payload
- depth, 8, FIFO capacity in words; power of two, ≥ 2
- cnt_w, $clog2(depth+1), width of the occupancy count
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (clears all state)
- push  in  1  device writes D_push this cycle
- D_push  in  width  word to enqueue
- pop  in  1  bus consumes the current head word this cycle
- D_pop  out  width  current head word (FWFT); all zeros when empty
- pndng  out  1  FIFO non-empty
- full  out  1  occupancy == depth
- count  out  cnt_w  current occupancy, 0..depth
- overflow  out  1  sticky: a push was dropped while full
- clr_ovf  in  1  synchronous clear of overflow

## Operation
- Storage: depth×width register array; read pointer rd_ptr and write pointer wr_ptr, each $clog2(depth) bits, wrapping modulo depth; separate count register (no pointer-compare full/empty).
- Effective operations per cycle:
  - do_pop = pop & pndng
  - do_push = push & (~full | do_pop)
- do_push: mem[wr_ptr] ← D_push; wr_ptr++.
- do_pop: rd_ptr++.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Push while full without a pop: word dropped; overflow ← 1; no other state changes.
- Push and pop while full: both accepted; count stays depth.
- Pop while empty: ignored, no error. Push and pop while empty: push accepted, pop ignored; count becomes 1.
- overflow: set has priority over clr_ovf in the same cycle; cleared only by clr_ovf or reset.
- D_pop = pndng ? mem[rd_ptr] : 0 (combinational from registered state).
- pndng = (count != 0); full = (count == depth).
- The block does not interpret the destination field; it passes words through bit-exact.

## Timing
- Reset (reset low, asynchronous): rd_ptr = wr_ptr = 0, count = 0, overflow = 0. Outputs: pndng = 0, full = 0, count = 0, D_pop = 0, overflow = 0. Memory contents are not cleared; they are masked by D_pop gating.
- Reset asserted mid-operation discards all queued words immediately, with no clock edge required. Release is synchronous to the next rising edge.
- Push latency: a word pushed at edge N is visible on D_pop and pndng after edge N, when the FIFO was empty.
- Pop: the bus samples D_pop while asserting pop; at that edge the next word (or zeros) appears.
- Back-to-back push every cycle and pop every cycle sustain 1 word/cycle with no bubbles.
- Flags and count update on the same edge as the operation that changes them; no registered-output lag.

## Test plan
- Reset then idle: pndng=0, full=0, count=0, D_pop=16'h0000, overflow=0. Assert reset low mid-stream with 3 words queued: all of these flags drop immediately, without waiting for a clock.
- Push 16'h0155, 16'h02AA, 16'h03FF on consecutive cycles, then pop 3 times. D_pop shows 0155, 02AA, 03FF in order; count goes 1,2,3 then 2,1,0; pndng falls after the third pop.
- Fill with 8 words 16'h0100..16'h0107: full=1, count=8. Then push 16'hDEAD: dropped, overflow=1, count stays 8. Pop all 8: the sequence is 0100..0107 with no DEAD.
- At full, push 16'h0A0A and pop in the same cycle: count stays 8, full stays 1, overflow stays 0. Drain: 16'h0A0A is the last word out.
- With the FIFO empty, pop alone: no change. Then push 16'h0303 together with pop: count=1, D_pop=16'h0303.
- With overflow=1, assert clr_ovf together with a dropped push: overflow stays 1. Then clr_ovf alone: overflow=0. Run 20 push/pop cycles to wrap the pointers: all data arrives in order.

Source files
------------

// File: rtl/device_fifo.sv
// Per-device transmit FIFO feeding the shared bus: first-word-fall-through head,
// occupancy count, full flag and a sticky overflow error.
module device_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] D_push_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] D_pop_o,
  output logic             pndng_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  input  logic             clr_ovf_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             do_push, do_pop;

  assign pndng_o    = (count_q != '0);
  assign full_o     = (count_q == FULL_CNT);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign D_pop_o    = pndng_o ? mem_q[rd_ptr_q] : '0;

  // A pop frees a slot in the same cycle, so a push at full is accepted alongside it.
  assign do_pop  = pop_i & pndng_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
    // Setting wins over clearing so a drop in the clearing cycle is never lost.
    if (push_i && !do_push) overflow_d = 1'b1;
    else if (clr_ovf_i)     overflow_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; stale contents are hidden by the D_pop gating.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= D_push_i;
  end

endmodule
